// File: rtl/aer_event_readout.sv
// aer_event_readout: consumer end of the AER pixel arbitration tree.
// Captures the granted pixel address with a free-running timestamp, pushes
// it into a first-word-fall-through event FIFO and pulses grp_release_o so
// the tree can re-arbitrate. Events drain over a valid/ready stream.
// Optional build macro AER_DROP_ON_FULL_EN: a full FIFO drops the event
// (counted on drop_cnt_o) rather than stalling the arbitration tree.
module aer_event_readout #(
  parameter int ADD_W      = 4,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    active_i,
  input  logic [ADD_W-1:0]        x_add_i,
  input  logic [ADD_W-1:0]        y_add_i,
  output logic                    grp_release_o,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [TS_W+2*ADD_W-1:0] evt_data_o,
  output logic [CNT_W-1:0]        fifo_count_o,
  output logic                    busy_o
`ifdef AER_DROP_ON_FULL_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef AER_DROP_ON_FULL_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [ADD_W-1:0] y;
    logic [ADD_W-1:0] x;
  } evt_t;

  typedef enum logic [1:0] {IDLE, RELEASE, SETTLE} state_t;

  state_t           state;
  logic [TS_W-1:0]  ts;
  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, cap, push, pop;

  // Full is judged on start-of-cycle occupancy; a same-cycle pop does not free a slot.
  assign full        = (fifo_count_o == CNT_W'(FIFO_DEPTH));
  assign cap         = (state == IDLE) && active_i;
  assign push        = cap && !full;
  assign evt_valid_o = (fifo_count_o != '0);
  assign pop         = evt_valid_o && evt_ready_i;
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;

  // Free-running timestamp, wraps naturally at 2^TS_W.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  // Capture / release / settle sequencer with registered handshake outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state         <= IDLE;
      grp_release_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (active_i && (!full || DROP_EN)) begin
            state         <= RELEASE;
            grp_release_o <= 1'b1;
            busy_o        <= 1'b1;
          end
        end
        RELEASE: begin
          state         <= SETTLE;
          grp_release_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Event storage; contents are masked by the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{ts: ts, y: y_add_i, x: x_add_i};
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + 1'b1;
        2'b01:   fifo_count_o <= fifo_count_o - 1'b1;
        default: fifo_count_o <= fifo_count_o;
      endcase
    end
  end

`ifdef AER_DROP_ON_FULL_EN
  // Saturating count of events discarded because the FIFO was full.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                              drop_cnt_o <= '0;
    else if (cap && full && drop_cnt_o != '1)  drop_cnt_o <= drop_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_aer_event_readout.sv
// Bench for aer_event_readout: scenario tasks against a queue-based
// behavioural model of capture pacing, FIFO order and timestamps.
module tb_aer_event_readout;
  localparam int DEPTH = 8;

  logic        clk_i = 1'b0, reset_i = 1'b0, active_i = 1'b0, evt_ready_i = 1'b0;
  logic [3:0]  x_add_i = '0, y_add_i = '0;
  logic        grp_release_o, evt_valid_o, busy_o;
  logic [23:0] evt_data_o;
  logic [3:0]  fifo_count_o;
`ifdef AER_DROP_ON_FULL_EN
  logic [15:0] drop_cnt_o;
`endif

  aer_event_readout dut (
    .clk_i(clk_i), .reset_i(reset_i), .active_i(active_i),
    .x_add_i(x_add_i), .y_add_i(y_add_i), .grp_release_o(grp_release_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
    .fifo_count_o(fifo_count_o), .busy_o(busy_o)
`ifdef AER_DROP_ON_FULL_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0, nerr = 0;

  // Reference model: cycles since reset give the timestamp, a queue holds the
  // events, and "cool" counts the cycles left before the next capture is allowed.
  int          m_ts, m_cool, m_drop;
  bit          m_rel;
  logic [23:0] m_q[$];

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_ts = 0; m_cool = 0; m_drop = 0; m_rel = 0; m_q.delete();
    end else begin
      bit pop_now, take;
      pop_now = (m_q.size() > 0) && evt_ready_i;
      take    = 0;
      m_rel   = 0;
      if (m_cool == 0 && active_i) begin
        if (m_q.size() < DEPTH) begin
          take = 1; m_rel = 1; m_cool = 2;
        end
`ifdef AER_DROP_ON_FULL_EN
        else begin
          m_rel = 1; m_cool = 2;
          if (m_drop < 65535) m_drop++;
        end
`endif
      end else if (m_cool > 0) m_cool--;
      if (pop_now) void'(m_q.pop_front());
      if (take) m_q.push_back({m_ts[15:0], y_add_i, x_add_i});
      m_ts = (m_ts + 1) % 65536;
    end
  end

  function automatic logic [23:0] exp_data();
    return (m_q.size() > 0) ? m_q[0] : 24'h0;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 0; active_i = 0; evt_ready_i = 0;
    #2 reset_i = 1;
  endtask

  task automatic test_reset();
    do_reset();
    active_i = 1; evt_ready_i = 0;
    repeat (5) @(negedge clk_i);
    reset_i = 0;
    #1;
    nvec++; if ({grp_release_o, evt_valid_o, busy_o} !== 3'b000) begin
      nerr++; $display("FAIL reset_ctl got %b exp 000", {grp_release_o, evt_valid_o, busy_o}); end
    nvec++; if (evt_data_o !== 24'h0) begin
      nerr++; $display("FAIL reset_data got %h exp 000000", evt_data_o); end
    nvec++; if (fifo_count_o !== 4'd0) begin
      nerr++; $display("FAIL reset_count got %0d exp 0", fifo_count_o); end
`ifdef AER_DROP_ON_FULL_EN
    nvec++; if (drop_cnt_o !== 16'd0) begin
      nerr++; $display("FAIL reset_drop got %0d exp 0", drop_cnt_o); end
`endif
    active_i = 0;
    #1 reset_i = 1;
  endtask

  task automatic test_single();
    do_reset();
    x_add_i = 4'd3; y_add_i = 4'd5;
    repeat (10) @(negedge clk_i);
    nvec++; if (grp_release_o !== 1'b0 || evt_valid_o !== 1'b0) begin
      nerr++; $display("FAIL single_pre rel=%b vld=%b exp 0 0", grp_release_o, evt_valid_o); end
    active_i = 1;
    @(negedge clk_i);
    active_i = 0;
    nvec++; if (grp_release_o !== 1'b1 || busy_o !== 1'b1) begin
      nerr++; $display("FAIL single_rel rel=%b busy=%b exp 1 1", grp_release_o, busy_o); end
    nvec++; if (evt_valid_o !== 1'b1 || evt_data_o !== 24'h000A53) begin
      nerr++; $display("FAIL single_data vld=%b data=%h exp 1 000a53", evt_valid_o, evt_data_o); end
    @(negedge clk_i);
    nvec++; if (grp_release_o !== 1'b0 || busy_o !== 1'b1) begin
      nerr++; $display("FAIL single_settle rel=%b busy=%b exp 0 1", grp_release_o, busy_o); end
    @(negedge clk_i);
    nvec++; if (busy_o !== 1'b0 || evt_data_o !== 24'h000A53) begin
      nerr++; $display("FAIL single_hold busy=%b data=%h exp 0 000a53", busy_o, evt_data_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  xs[9], ys[9];
    logic [23:0] got[$], want[$];
    int          rel_at[$];
    do_reset();
    evt_ready_i = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 9) begin
        xs[c] = 4'($urandom); ys[c] = 4'($urandom);
        active_i = 1; x_add_i = xs[c]; y_add_i = ys[c];
      end else active_i = 0;
      @(negedge clk_i);
      if (grp_release_o) rel_at.push_back(c + 1);
      if (evt_valid_o) got.push_back(evt_data_o);
    end
    for (int k = 0; k < 3; k++) want.push_back({16'(3 * k), ys[3 * k], xs[3 * k]});
    nvec++; if (rel_at.size() != 3 || rel_at[0] != 1 || rel_at[1] != 4 || rel_at[2] != 7) begin
      nerr++; $display("FAIL b2b_release got %p exp '{1,4,7}", rel_at); end
    nvec++; if (got != want) begin
      nerr++; $display("FAIL b2b_events got %p exp %p", got, want); end
  endtask

`ifndef AER_DROP_ON_FULL_EN
  task automatic test_full_stall();
    int rels = 0;
    do_reset();
    evt_ready_i = 0; active_i = 1;
    for (int c = 0; c < 30; c++) begin
      x_add_i = 4'($urandom); y_add_i = 4'($urandom);
      @(negedge clk_i);
      rels += int'(grp_release_o);
    end
    nvec++; if (fifo_count_o !== 4'd8 || rels != 8) begin
      nerr++; $display("FAIL stall_full count=%0d rels=%0d exp 8 8", fifo_count_o, rels); end
    nvec++; if (grp_release_o !== 1'b0 || busy_o !== 1'b0) begin
      nerr++; $display("FAIL stall_hold rel=%b busy=%b exp 0 0", grp_release_o, busy_o); end
    evt_ready_i = 1;
    @(negedge clk_i);
    evt_ready_i = 0;
    nvec++; if (fifo_count_o !== 4'd7 || grp_release_o !== 1'b0) begin
      nerr++; $display("FAIL stall_pop count=%0d rel=%b exp 7 0", fifo_count_o, grp_release_o); end
    @(negedge clk_i);
    active_i = 0;
    nvec++; if (fifo_count_o !== 4'd8 || grp_release_o !== 1'b1) begin
      nerr++; $display("FAIL stall_9th count=%0d rel=%b exp 8 1", fifo_count_o, grp_release_o); end
    nvec++; if (evt_data_o !== exp_data()) begin
      nerr++; $display("FAIL stall_head got %h exp %h", evt_data_o, exp_data()); end
  endtask
`else
  task automatic test_drop();
    int rels = 0;
    logic [23:0] before[$];
    do_reset();
    evt_ready_i = 0; active_i = 1;
    for (int c = 0; c < 22; c++) begin
      x_add_i = 4'($urandom); y_add_i = 4'($urandom);
      @(negedge clk_i);
    end
    before = m_q;
    for (int c = 22; c < 33; c++) begin
      x_add_i = 4'($urandom); y_add_i = 4'($urandom);
      @(negedge clk_i);
      rels += int'(grp_release_o);
    end
    active_i = 0;
    nvec++; if (rels != 3 || drop_cnt_o !== 16'd3) begin
      nerr++; $display("FAIL drop_count rels=%0d drop=%0d exp 3 3", rels, drop_cnt_o); end
    nvec++; if (fifo_count_o !== 4'd8 || m_q != before) begin
      nerr++; $display("FAIL drop_fifo count=%0d exp 8", fifo_count_o); end
    evt_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      nvec++; if (evt_data_o !== {16'(3 * k), before[k][7:0]}) begin
        nerr++; $display("FAIL drop_drain%0d got %h exp %h", k, evt_data_o, {16'(3 * k), before[k][7:0]}); end
      @(negedge clk_i);
    end
    evt_ready_i = 0;
  endtask
`endif

  task automatic test_push_pop();
    do_reset();
    evt_ready_i = 0; active_i = 1;
    for (int c = 0; c < 12; c++) begin
      x_add_i = 4'($urandom); y_add_i = 4'($urandom);
      @(negedge clk_i);
    end
    active_i = 0;
    repeat (2) @(negedge clk_i);
    nvec++; if (fifo_count_o !== 4'd4 || evt_data_o[23:8] !== 16'd0) begin
      nerr++; $display("FAIL pp_pre count=%0d ts=%0d exp 4 0", fifo_count_o, evt_data_o[23:8]); end
    active_i = 1; evt_ready_i = 1; x_add_i = 4'($urandom); y_add_i = 4'($urandom);
    @(negedge clk_i);
    active_i = 0; evt_ready_i = 0;
    nvec++; if (fifo_count_o !== 4'd4 || grp_release_o !== 1'b1 || evt_data_o[23:8] !== 16'd3) begin
      nerr++; $display("FAIL pp_same count=%0d rel=%b ts=%0d exp 4 1 3", fifo_count_o, grp_release_o, evt_data_o[23:8]); end
    evt_ready_i = 1;
    for (int k = 0; k < 5; k++) begin
      nvec++; if (evt_valid_o !== (m_q.size() > 0) || evt_data_o !== exp_data()) begin
        nerr++; $display("FAIL pp_drain%0d got %b/%h exp %b/%h", k, evt_valid_o, evt_data_o, m_q.size() > 0, exp_data()); end
      @(negedge clk_i);
    end
    evt_ready_i = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready_i = 0; active_i = 1;
    repeat (4) @(negedge clk_i);
    active_i = 0;
    nvec++; if (grp_release_o !== 1'b1 || fifo_count_o !== 4'd2) begin
      nerr++; $display("FAIL mid_pre rel=%b count=%0d exp 1 2", grp_release_o, fifo_count_o); end
    #1 reset_i = 0;
    #1;
    nvec++; if ({grp_release_o, evt_valid_o, busy_o, fifo_count_o, evt_data_o} !== '0) begin
      nerr++; $display("FAIL mid_async rel=%b vld=%b busy=%b count=%0d data=%h exp all 0",
                       grp_release_o, evt_valid_o, busy_o, fifo_count_o, evt_data_o); end
    #1 reset_i = 1;
    @(negedge clk_i);
    nvec++; if (evt_valid_o !== 1'b0 || fifo_count_o !== 4'd0) begin
      nerr++; $display("FAIL mid_after vld=%b count=%0d exp 0 0", evt_valid_o, fifo_count_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      active_i    = ($urandom_range(0, 3) != 0);
      evt_ready_i = ($urandom_range(0, 2) == 0);
      x_add_i = 4'($urandom); y_add_i = 4'($urandom);
      @(negedge clk_i);
      nvec++; if (grp_release_o !== m_rel || busy_o !== (m_cool != 0)) begin
        nerr++; $display("FAIL rnd_ctl c=%0d rel=%b busy=%b exp %b %b", c, grp_release_o, busy_o, m_rel, m_cool != 0); end
      nvec++; if (fifo_count_o !== 4'(m_q.size()) || evt_valid_o !== (m_q.size() > 0)) begin
        nerr++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, fifo_count_o, m_q.size()); end
      nvec++; if (evt_data_o !== exp_data()) begin
        nerr++; $display("FAIL rnd_data c=%0d got %h exp %h", c, evt_data_o, exp_data()); end
`ifdef AER_DROP_ON_FULL_EN
      nvec++; if (drop_cnt_o !== 16'(m_drop)) begin
        nerr++; $display("FAIL rnd_drop c=%0d got %0d exp %0d", c, drop_cnt_o, m_drop); end
`endif
    end
    active_i = 0; evt_ready_i = 0;
  endtask

  task automatic test_ts_wrap();
    do_reset();
    evt_ready_i = 0;
    repeat (65535) @(negedge clk_i);
    active_i = 1; x_add_i = 4'($urandom); y_add_i = 4'($urandom);
    repeat (4) @(negedge clk_i);
    active_i = 0;
    nvec++; if (fifo_count_o !== 4'd2 || evt_data_o[23:8] !== 16'hFFFF) begin
      nerr++; $display("FAIL wrap_first count=%0d ts=%h exp 2 ffff", fifo_count_o, evt_data_o[23:8]); end
    evt_ready_i = 1;
    @(negedge clk_i);
    evt_ready_i = 0;
    nvec++; if (fifo_count_o !== 4'd1 || evt_data_o[23:8] !== 16'h0002) begin
      nerr++; $display("FAIL wrap_second count=%0d ts=%h exp 1 0002", fifo_count_o, evt_data_o[23:8]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifndef AER_DROP_ON_FULL_EN
    test_full_stall();
`else
    test_drop();
`endif
    test_push_pop();
    test_reset_mid();
    test_random();
    test_ts_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
